blvds_link_ctrl: RTL and testbench

Half-duplex frame controller for the bus-LVDS link transceiver. It sits directly upstream of the transceiver: it drives the transceiver's serial transmit bit (`doutp`) and output enable (`oe`), and it consumes the transceiver's received bit (`din`). It serializes parallel words into framed bit streams, owns bus direction and turnaround, and deserializes and checks incoming frames when the bus is released.

---
 rtl/blvds_link_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_blvds_link_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blvds_link_ctrl.sv
// blvds_link_ctrl
//   Half-duplex frame controller sitting upstream of a bus-LVDS transceiver.
//   Serializes words into framed bit streams (preamble, start, data LSB first,
//   even parity, stop), owns bus direction and turnaround, and deserializes
//   and checks incoming frames while the bus is released.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   tx_data/tx_valid    word to send; tx_ready (registered) accepts it
//   rx_data/rx_valid    last received payload, one-cycle completion pulse
//   rx_err              parity or stop error, qualified by rx_valid
//   busy                controller is not idle
//   doutp/oe            registered serial bit and drive enable to transceiver
//   din                 received bit from transceiver (0 while oe=1)
module blvds_link_ctrl #(
    parameter int DATA_W   = 8,
    parameter int BIT_CYC  = 4,
    parameter int TURN_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              busy,
    output logic              doutp,
    output logic              oe,
    input  logic              din
);

    localparam int CNT_W  = $clog2(BIT_CYC + TURN_CYC + 1);
    localparam int BITS_W = $clog2(DATA_W + 3);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0]  TURN_LAST = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BITS_W-1:0] TX_LAST   = BITS_W'(DATA_W + 2);
    localparam logic [BITS_W-1:0] RX_LAST   = BITS_W'(DATA_W);
    localparam logic [BITS_W-1:0] BITS_ONE  = BITS_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        TX_PRE,
        TX_SHIFT,
        TX_TURN,
        RX_START,
        RX_SHIFT,
        RX_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BITS_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    hi_cnt_q, hi_cnt_d;
    logic                armed_q, armed_d;
    logic                sync1_q, sync1_d;
    logic                dsync_q, dsync_d;
    logic                dsync_prev_q, dsync_prev_d;
    logic [DATA_W+2:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W:0]     rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_err_q, rx_err_d;
    logic                tx_ready_q, tx_ready_d;
    logic                busy_q, busy_d;
    logic                doutp_q, doutp_d;
    logic                oe_q, oe_d;

    logic                edge_det;
    logic                armed_clr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        bit_cnt_d    = bit_cnt_q;
        hi_cnt_d     = '0;
        armed_d      = armed_q;
        sync1_d      = din;
        dsync_d      = sync1_q;
        dsync_prev_d = dsync_q;
        tx_sh_d      = tx_sh_q;
        rx_sh_d      = rx_sh_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_err_d     = rx_err_q;
        doutp_d      = doutp_q;
        oe_d         = oe_q;
        armed_clr    = 1'b0;

        edge_det = armed_q & dsync_prev_q & ~dsync_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (edge_det) begin
                    state_d = RX_START;
                end else if (tx_valid && tx_ready_q) begin
                    state_d = TX_PRE;
                    tx_sh_d = {1'b1, ^tx_data, tx_data, 1'b0};
                    oe_d    = 1'b1;
                    doutp_d = 1'b1;
                end
            end
            TX_PRE: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = TX_SHIFT;
                    cnt_d   = '0;
                    doutp_d = tx_sh_q[0];
                end
            end
            TX_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_cnt_q == TX_LAST) begin
                        state_d = TX_TURN;
                        oe_d    = 1'b0;
                        doutp_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BITS_ONE;
                        tx_sh_d   = tx_sh_q >> 1;
                        doutp_d   = tx_sh_q[1];
                    end
                end
            end
            TX_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d   = IDLE;
                    armed_clr = 1'b1;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = dsync_q ? IDLE : RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    rx_sh_d = {dsync_q, rx_sh_q[DATA_W:1]};
                    if (bit_cnt_q == RX_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BITS_ONE;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    state_d    = IDLE;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q[DATA_W-1:0];
                    // Data plus parity has odd weight exactly when parity is wrong.
                    rx_err_d   = (^rx_sh_q) | ~dsync_q;
                    armed_clr  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Arm after BIT_CYC consecutive high samples while idle.
        if (state_q == IDLE && dsync_q) begin
            if (hi_cnt_q == BIT_LAST) begin
                hi_cnt_d = hi_cnt_q;
                armed_d  = 1'b1;
            end else begin
                hi_cnt_d = hi_cnt_q + CNT_ONE;
            end
        end
        if (armed_clr) begin
            armed_d = 1'b0;
        end

        // tx_ready is registered, so the falling edge that edge_det will see
        // next cycle is predicted from the synchronizer stages (dsync high,
        // first stage already low); this keeps tx_ready low in the edge cycle.
        tx_ready_d = (state_d == IDLE) & ~(armed_d & dsync_q & ~sync1_q);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            armed_q      <= 1'b0;
            sync1_q      <= 1'b1;
            dsync_q      <= 1'b1;
            dsync_prev_q <= 1'b1;
            tx_sh_q      <= '0;
            rx_sh_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_err_q     <= 1'b0;
            tx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            doutp_q      <= 1'b1;
            oe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            armed_q      <= armed_d;
            sync1_q      <= sync1_d;
            dsync_q      <= dsync_d;
            dsync_prev_q <= dsync_prev_d;
            tx_sh_q      <= tx_sh_d;
            rx_sh_q      <= rx_sh_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_err_q     <= rx_err_d;
            tx_ready_q   <= tx_ready_d;
            busy_q       <= busy_d;
            doutp_q      <= doutp_d;
            oe_q         <= oe_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign busy     = busy_q;
    assign doutp    = doutp_q;
    assign oe       = oe_q;

endmodule

// File: tb/tb_blvds_link_ctrl.sv
// tb_blvds_link_ctrl
//   Directed bench for blvds_link_ctrl with BIT_CYC=4, TURN_CYC=2, DATA_W=8.
//   The transceiver is modelled by forcing din to 0 while oe is high.
module tb_blvds_link_ctrl;

    localparam int DW = 8;
    localparam int BC = 4;
    localparam int TC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_err;
    logic          busy;
    logic          doutp;
    logic          oe;
    logic          din;
    logic          line = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign din = oe ? 1'b0 : line;

    blvds_link_ctrl #(
        .DATA_W  (DW),
        .BIT_CYC (BC),
        .TURN_CYC(TC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_err  (rx_err),
        .busy    (busy),
        .doutp   (doutp),
        .oe      (oe),
        .din     (din)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, tx_ready}, 32'd1);
    endtask

    // Returns at negedge #1 after the accept edge.
    task automatic tx_accept(input logic [DW-1:0] d, input string tag);
        wait_ready({tag, "_ready"});
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk({tag, "_oe1"},   {31'd0, oe},       32'd1);
        chk({tag, "_busy1"}, {31'd0, busy},     32'd1);
        chk({tag, "_rdy0"},  {31'd0, tx_ready}, 32'd0);
    endtask

    // Drives start/data/parity/stop on the line (BC clocks per bit) while
    // watching outputs. Optionally raises tx_valid at cycle tv_at.
    task automatic rx_frame(input logic [DW-1:0] d, input logic par, input logic stp,
                            input int tv_at,
                            output int npulse, output int lat,
                            output logic [DW-1:0] rd, output logic re,
                            output logic rdy_at_tv, output int oe_first);
        logic [DW+2:0] bits;
        bits = {stp, par, d, 1'b0};
        npulse = 0;
        lat = -1;
        rd = '0;
        re = 1'b0;
        rdy_at_tv = 1'b1;
        oe_first = -1;
        for (int c = 0; c < 56; c++) begin
            line = (c < (DW + 3) * BC) ? bits[c / BC] : 1'b1;
            if (c == tv_at) begin
                tx_valid  = 1'b1;
                rdy_at_tv = tx_ready;
            end
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                npulse++;
                if (lat < 0) begin
                    lat = c + 1;
                    rd  = rx_data;
                    re  = rx_err;
                end
            end
            if (oe === 1'b1 && oe_first < 0) begin
                oe_first = c + 1;
                tx_valid = 1'b0;
            end
        end
        line = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int np;
        int lt;
        int oef;
        int cnt;
        logic [DW-1:0] rd;
        logic re;
        logic rdy_tv;
        logic [11:0] exp_a5;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_doutp",   {31'd0, doutp},    32'd1);
        chk("rst_oe",      {31'd0, oe},       32'd0);
        chk("rst_ready",   {31'd0, tx_ready}, 32'd0);
        chk("rst_rxvalid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rxerr",   {31'd0, rx_err},   32'd0);
        chk("rst_rxdata",  {24'd0, rx_data},  32'd0);
        chk("rst_busy",    {31'd0, busy},     32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_ready", {31'd0, tx_ready}, 32'd1);

        // 1: TX 0xA5. Index 0 pre, 1 start, 2..9 data LSB first, 10 parity, 11 stop.
        exp_a5 = 12'b1_0_10100101_0_1;
        tx_accept(8'hA5, "tx1");
        for (int n = 1; n <= 48; n++) begin
            if (n > 1) @(negedge clk);
            chk($sformatf("tx1_oe_%0d", n),    {31'd0, oe},    32'd1);
            chk($sformatf("tx1_bit_%0d", n),   {31'd0, doutp}, {31'd0, exp_a5[(n - 1) / BC]});
        end
        @(negedge clk);
        chk("tx1_oe_fall",   {31'd0, oe},       32'd0);
        chk("tx1_doutp_idl", {31'd0, doutp},    32'd1);
        chk("tx1_rdy_49",    {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        chk("tx1_rdy_50",    {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        chk("tx1_rdy_51",    {31'd0, tx_ready}, 32'd1);
        chk("tx1_busy_51",   {31'd0, busy},     32'd0);

        // 2: RX 0x3C, good parity and stop
        line = 1'b1;
        repeat (8) @(negedge clk);
        rx_frame(8'h3C, 1'b0, 1'b1, -1, np, lt, rd, re, rdy_tv, oef);
        chk("rx2_pulses", np, 32'd1);
        chk("rx2_lat",    lt, 32'd45);
        chk("rx2_data",   {24'd0, rd}, 32'h3C);
        chk("rx2_err",    {31'd0, re}, 32'd0);
        chk("rx2_hold",   {24'd0, rx_data}, 32'h3C);
        chk("rx2_vlow",   {31'd0, rx_valid}, 32'd0);

        // 3: RX 0x01 with wrong parity, then with stop=0
        repeat (8) @(negedge clk);
        rx_frame(8'h01, 1'b0, 1'b1, -1, np, lt, rd, re, rdy_tv, oef);
        chk("rx3p_pulses", np, 32'd1);
        chk("rx3p_data",   {24'd0, rd}, 32'h01);
        chk("rx3p_err",    {31'd0, re}, 32'd1);
        repeat (8) @(negedge clk);
        rx_frame(8'h01, 1'b1, 1'b0, -1, np, lt, rd, re, rdy_tv, oef);
        chk("rx3s_pulses", np, 32'd1);
        chk("rx3s_data",   {24'd0, rd}, 32'h01);
        chk("rx3s_err",    {31'd0, re}, 32'd1);

        // 4: one-clock glitch while armed
        repeat (8) @(negedge clk);
        cnt = 0;
        line = 1'b0;
        @(negedge clk);
        line = 1'b1;
        if (rx_valid === 1'b1) cnt++;
        @(negedge clk);
        if (rx_valid === 1'b1) cnt++;
        chk("gl_rdy_n2", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        if (rx_valid === 1'b1) cnt++;
        chk("gl_busy_n3", {31'd0, busy},     32'd1);
        chk("gl_rdy_n3",  {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        if (rx_valid === 1'b1) cnt++;
        @(negedge clk);
        if (rx_valid === 1'b1) cnt++;
        chk("gl_rdy_n5",  {31'd0, tx_ready}, 32'd1);
        chk("gl_busy_n5", {31'd0, busy},     32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) cnt++;
        end
        chk("gl_no_valid", cnt, 32'd0);

        // 5: tx_valid raised in the edge-detect cycle of an incoming frame
        repeat (8) @(negedge clk);
        tx_data = 8'hC3;
        rx_frame(8'h5A, 1'b0, 1'b1, 2, np, lt, rd, re, rdy_tv, oef);
        chk("col_rdy_edge", {31'd0, rdy_tv}, 32'd0);
        chk("col_pulses",   np, 32'd1);
        chk("col_lat",      lt, 32'd45);
        chk("col_data",     {24'd0, rd}, 32'h5A);
        chk("col_err",      {31'd0, re}, 32'd0);
        chk("col_accept",   oef, 32'd46);
        wait_ready("col_txdone");

        // 6: reset during data bit 5 of a TX frame (0x20: bit 5 only)
        tx_accept(8'h20, "tx6");
        repeat (27) @(negedge clk);
        chk("tx6_bit4", {31'd0, doutp}, 32'd0);
        repeat (2) @(negedge clk);
        chk("tx6_bit5", {31'd0, doutp}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("tx6_rst_oe",    {31'd0, oe},       32'd0);
        chk("tx6_rst_doutp", {31'd0, doutp},    32'd1);
        chk("tx6_rst_busy",  {31'd0, busy},     32'd0);
        chk("tx6_rst_rv",    {31'd0, rx_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("tx6_rel_rdy",   {31'd0, tx_ready}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) cnt++;
        end
        chk("tx6_no_valid", cnt, 32'd0);
        chk("tx6_oe_idle",  {31'd0, oe}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
